// File: rtl/gray_counter_if.sv
// Control and count bus of the Gray counter; master drives controls, slave returns the count.
interface gray_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_gray;
    logic [WIDTH-1:0] gray_out;
    logic [WIDTH-1:0] bin_out;
    logic             carry;

    modport master (
        output en, up, load, load_gray,
        input  gray_out, bin_out, carry
    );

    modport slave (
        input  en, up, load, load_gray,
        output gray_out, bin_out, carry
    );
endinterface

// File: rtl/gray_counter.sv
// Up/down Gray counter with Gray-coded load and wrap/saturate ends; binary state, Gray view registered alongside.
// Latency: 1 cycle from en/up/load/rst_n sampling edge to gray_out/bin_out/carry.
// Backpressure: none; one step per enabled cycle, load has priority over the step.
module gray_counter #(
    parameter int WIDTH    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    gray_counter_if.slave cnt
);
    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             carry_q;
    logic [WIDTH-1:0] bin_d;
    logic             carry_d;
    logic [WIDTH-1:0] load_bin;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        logic acc;
        acc      = 1'b0;
        load_bin = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc         = acc ^ cnt.load_gray[i];
            load_bin[i] = acc;
        end
    end

    always_comb begin
        bin_d   = bin_q;
        carry_d = 1'b0;
        if (cnt.load) begin
            bin_d = load_bin;
        end else if (cnt.en) begin
            if (cnt.up) begin
                if (bin_q == MAX_VAL) begin
                    carry_d = 1'b1;
                    if (!SATURATE) bin_d = '0;
                end else begin
                    bin_d = bin_q + ONE;
                end
            end else begin
                if (bin_q == '0) begin
                    carry_d = 1'b1;
                    if (!SATURATE) bin_d = MAX_VAL;
                end else begin
                    bin_d = bin_q - ONE;
                end
            end
        end
    end

    // Gray register is fed from the next binary value so both views change on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q   <= '0;
            gray_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            gray_q  <= bin_d ^ (bin_d >> 1);
            carry_q <= carry_d;
        end
    end

    assign cnt.bin_out  = bin_q;
    assign cnt.gray_out = gray_q;
    assign cnt.carry    = carry_q;
endmodule

// File: tb/tb_gray_counter.sv
// Drives a wrapping and a saturating counter with identical stimulus and checks both against an arithmetic model.
module tb_gray_counter;
    localparam int W    = 4;
    localparam int MAXI = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gray_counter_if #(.WIDTH(W)) if_w ();
    gray_counter_if #(.WIDTH(W)) if_s ();

    gray_counter #(.WIDTH(W), .SATURATE(1'b0)) dut_w (.clk(clk), .rst_n(rst_n), .cnt(if_w));
    gray_counter #(.WIDTH(W), .SATURATE(1'b1)) dut_s (.clk(clk), .rst_n(rst_n), .cnt(if_s));

    int n_chk  = 0;
    int n_fail = 0;
    int m_bin[2]   = '{0, 0};
    bit m_carry[2] = '{1'b0, 1'b0};
    int sweep_g[17] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0, 1};

    function automatic int g2b(int g);
        int b = 0;
        for (int k = 0; k < W; k++) b = b ^ (g >> k);
        return b;
    endfunction

    function automatic int b2g(int b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(int d, bit r, bit e, bit u, bit l, int lg);
        if (!r) begin
            m_bin[d] = 0; m_carry[d] = 1'b0;
        end else if (l) begin
            m_bin[d] = g2b(lg & MAXI); m_carry[d] = 1'b0;
        end else if (e) begin
            if (u) begin
                if (m_bin[d] == MAXI) begin
                    m_carry[d] = 1'b1;
                    if (d == 0) m_bin[d] = 0;
                end else begin
                    m_bin[d] = m_bin[d] + 1; m_carry[d] = 1'b0;
                end
            end else begin
                if (m_bin[d] == 0) begin
                    m_carry[d] = 1'b1;
                    if (d == 0) m_bin[d] = MAXI;
                end else begin
                    m_bin[d] = m_bin[d] - 1; m_carry[d] = 1'b0;
                end
            end
        end else begin
            m_carry[d] = 1'b0;
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check both DUTs just after it.
    task automatic cyc(bit r, bit e, bit u, bit l, int lg);
        logic [W-1:0] lgv;
        int prev_g;
        lgv    = lg[W-1:0];
        rst_n  = r;
        if_w.en = e; if_w.up = u; if_w.load = l; if_w.load_gray = lgv;
        if_s.en = e; if_s.up = u; if_s.load = l; if_s.load_gray = lgv;
        prev_g = b2g(m_bin[0]);
        @(posedge clk);
        model_step(0, r, e, u, l, lg);
        model_step(1, r, e, u, l, lg);
        #1;
        check("wrap_bin",   if_w.bin_out,  m_bin[0]);
        check("wrap_gray",  if_w.gray_out, b2g(m_bin[0]));
        check("wrap_carry", if_w.carry,    m_carry[0]);
        check("sat_bin",    if_s.bin_out,  m_bin[1]);
        check("sat_gray",   if_s.gray_out, b2g(m_bin[1]));
        check("sat_carry",  if_s.carry,    m_carry[1]);
        if (r && !l && e)
            check("wrap_onebit", $countones(if_w.gray_out ^ prev_g[W-1:0]), 1);
    endtask

    initial begin
        // Reset held with en and load high.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'b1011);
            check("rst_gray", if_w.gray_out, 0);
            check("rst_bin",  if_w.bin_out,  0);
            check("rst_carry", if_w.carry,   0);
        end

        // Full up sweep with wrap.
        for (int i = 0; i < 17; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0, 0);
            check("sweep_gray",  if_w.gray_out, sweep_g[i]);
            check("sweep_carry", if_w.carry,    (i == 15) ? 1 : 0);
        end

        // Load Gray 1011, then count down twice.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b1011);
        check("load_bin", if_w.bin_out, 13);
        check("load_gray", if_w.gray_out, 4'b1011);
        check("load_carry", if_w.carry, 0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0);
        check("down1_bin", if_w.bin_out, 12);
        check("down1_gray", if_w.gray_out, 4'b1010);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0);
        check("down2_bin", if_w.bin_out, 11);
        check("down2_gray", if_w.gray_out, 4'b1110);

        // Down wrap from zero.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0);
        check("dwrap_bin", if_w.bin_out, 15);
        check("dwrap_gray", if_w.gray_out, 4'b1000);
        check("dwrap_carry", if_w.carry, 1);
        check("dsat_hold", if_s.bin_out, 0);
        check("dsat_carry", if_s.carry, 1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0);
        check("dwrap2_bin", if_w.bin_out, 14);
        check("dwrap2_gray", if_w.gray_out, 4'b1001);
        check("dwrap2_carry", if_w.carry, 0);

        // Saturate at the top.
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'b1000);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0, 0);
            check("sat_top_bin", if_s.bin_out, 15);
            check("sat_top_carry", if_s.carry, 1);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0);
        check("sat_back_bin", if_s.bin_out, 14);
        check("sat_back_carry", if_s.carry, 0);

        // Load beats en, then mid-count reset.
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'b0110);
        check("prio_bin", if_w.bin_out, 4);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 0);
        check("prio_s1", if_w.bin_out, 5);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 0);
        check("prio_s2", if_w.bin_out, 6);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 0);
        check("mid_rst", if_w.bin_out, 0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 0);
        check("rst_resume", if_w.bin_out, 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit r, e, u, l;
            int lg;
            r  = ($urandom_range(0, 19) != 0);
            l  = ($urandom_range(0, 9) == 0);
            e  = ($urandom_range(0, 9) < 7);
            u  = $urandom_range(0, 1);
            lg = $urandom_range(0, MAXI);
            cyc(r, e, u, l, lg);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
